pc_update: RTL and testbench

// Back half of the single-cycle Y86-64 SEQ datapath, sitting after the fetch stage.

---
 rtl/pc_update_if.sv | 32 +++
 rtl/pc_update.sv | 149 ++++++++++++++
 tb/tb_pc_update.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pc_update_if.sv
// Instruction/operand bundle between the fetch side and the SEQ back half.
// Single-cycle datapath: no handshake; inputs are consumed on every clk posedge.
interface pc_update_if;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [63:0] valM;
  logic [3:0]  dbg_id;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valE;
  logic        ZF;
  logic        SF;
  logic        OF;
  logic        Cnd;
  logic [63:0] PC_next;
  logic [63:0] rsp;
  logic [63:0] dbg_val;

  modport master (
    output icode, ifun, rA, rB, valC, valP, valM, dbg_id,
    input  valA, valB, valE, ZF, SF, OF, Cnd, PC_next, rsp, dbg_val
  );

  modport slave (
    input  icode, ifun, rA, rB, valC, valP, valM, dbg_id,
    output valA, valB, valE, ZF, SF, OF, Cnd, PC_next, rsp, dbg_val
  );
endinterface

// File: rtl/pc_update.sv
// Y86-64 SEQ back half: decode, execute, condition codes, write-back and PC select.
// Register file and CC are the only state; everything else is combinational.
module pc_update #(
  parameter logic [63:0] RCX_INIT = 64'd100,
  parameter logic [63:0] RBP_INIT = 64'd4,
  parameter logic [63:0] RSP_INIT = 64'd256
) (
  input logic        clk,
  input logic        reset,
  pc_update_if.slave bus
);
  localparam logic [3:0] R_NONE = 4'hF;
  localparam logic [3:0] R_RSP  = 4'h4;

  logic [63:0] regs [15];
  logic        zf_q, sf_q, of_q;

  logic [3:0]  src_a, src_b, dst_e, dst_m, alu_fun;
  logic [63:0] val_a, val_b, alu_a, alu_b, val_e, pc_next;
  logic        cnd, of_new;

  always_comb begin
    src_a = R_NONE;
    src_b = R_NONE;
    case (bus.icode)
      4'h2, 4'h4, 4'h6, 4'hA: src_a = bus.rA;
      4'h9, 4'hB:             src_a = R_RSP;
      default:                src_a = R_NONE;
    endcase
    case (bus.icode)
      4'h4, 4'h5, 4'h6:        src_b = bus.rB;
      4'h8, 4'h9, 4'hA, 4'hB:  src_b = R_RSP;
      default:                 src_b = R_NONE;
    endcase
  end

  assign val_a = (src_a == R_NONE) ? 64'd0 : regs[src_a];
  assign val_b = (src_b == R_NONE) ? 64'd0 : regs[src_b];

  always_comb begin
    alu_a = 64'd0;
    alu_b = 64'd0;
    case (bus.icode)
      4'h2, 4'h6:        alu_a = val_a;
      4'h3, 4'h4, 4'h5:  alu_a = bus.valC;
      4'h8, 4'hA:        alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      4'h9, 4'hB:        alu_a = 64'd8;
      default:           alu_a = 64'd0;
    endcase
    case (bus.icode)
      4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: alu_b = val_b;
      default:                                   alu_b = 64'd0;
    endcase
  end

  assign alu_fun = (bus.icode == 4'h6) ? bus.ifun : 4'h0;

  // Overflow is derived from operand/result sign bits, never from a wider sum.
  always_comb begin
    val_e  = 64'd0;
    of_new = 1'b0;
    case (alu_fun)
      4'h0: begin
        val_e  = alu_b + alu_a;
        of_new = (alu_a[63] == alu_b[63]) && (val_e[63] != alu_a[63]);
      end
      4'h1: begin
        val_e  = alu_b - alu_a;
        of_new = (alu_a[63] != alu_b[63]) && (val_e[63] != alu_b[63]);
      end
      4'h2:    val_e = alu_b & alu_a;
      4'h3:    val_e = alu_b ^ alu_a;
      default: val_e = 64'd0;
    endcase
  end

  always_comb begin
    cnd = 1'b0;
    if (bus.icode == 4'h2 || bus.icode == 4'h7) begin
      case (bus.ifun)
        4'h0:    cnd = 1'b1;
        4'h1:    cnd = (sf_q ^ of_q) | zf_q;
        4'h2:    cnd = sf_q ^ of_q;
        4'h3:    cnd = zf_q;
        4'h4:    cnd = !zf_q;
        4'h5:    cnd = !(sf_q ^ of_q);
        4'h6:    cnd = !(sf_q ^ of_q) && !zf_q;
        default: cnd = 1'b0;
      endcase
    end
  end

  always_comb begin
    dst_e = R_NONE;
    dst_m = R_NONE;
    case (bus.icode)
      4'h3, 4'h6:              dst_e = bus.rB;
      4'h2:                    dst_e = cnd ? bus.rB : R_NONE;
      4'h8, 4'h9, 4'hA, 4'hB:  dst_e = R_RSP;
      default:                 dst_e = R_NONE;
    endcase
    case (bus.icode)
      4'h5, 4'hB: dst_m = bus.rA;
      default:    dst_m = R_NONE;
    endcase
  end

  always_comb begin
    pc_next = bus.valP;
    case (bus.icode)
      4'h7:    pc_next = cnd ? bus.valC : bus.valP;
      4'h8:    pc_next = bus.valC;
      4'h9:    pc_next = bus.valM;
      default: pc_next = bus.valP;
    endcase
  end

  // The M write is issued last so popq %rsp leaves valM in %rsp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) regs[i] <= 64'd0;
      regs[1] <= RCX_INIT;
      regs[4] <= RSP_INIT;
      regs[5] <= RBP_INIT;
      zf_q    <= 1'b1;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      if (dst_e != R_NONE) regs[dst_e] <= val_e;
      if (dst_m != R_NONE) regs[dst_m] <= bus.valM;
      if (bus.icode == 4'h6) begin
        zf_q <= (val_e == 64'd0);
        sf_q <= val_e[63];
        of_q <= of_new;
      end
    end
  end

  assign bus.valA    = val_a;
  assign bus.valB    = val_b;
  assign bus.valE    = val_e;
  assign bus.ZF      = zf_q;
  assign bus.SF      = sf_q;
  assign bus.OF      = of_q;
  assign bus.Cnd     = cnd;
  assign bus.PC_next = pc_next;
  assign bus.rsp     = regs[R_RSP];
  assign bus.dbg_val = (bus.dbg_id == R_NONE) ? 64'd0 : regs[bus.dbg_id];
endmodule

// File: tb/tb_pc_update.sv
// Bench for pc_update: vector table of Y86 instructions with a scoreboard queue,
// plus hand-written reset and mid-instruction reset sequences.
module tb_pc_update;
  logic clk;
  logic reset;
  pc_update_if bus ();

  pc_update dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, valm;
    logic [63:0] exp_e;
    logic        exp_cnd;
    logic [63:0] exp_pc;
    logic [3:0]  chk_reg;
    logic [63:0] exp_reg;
    logic [63:0] exp_rsp;
    logic [2:0]  exp_flags;
  } vec_t;

  vec_t vecs [19];

  logic [128:0] exp_q [$];
  logic [130:0] post_q [$];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                              input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                              input logic [63:0] vm, input logic [63:0] e, input logic c,
                              input logic [63:0] pc, input logic [3:0] cr, input logic [63:0] rv,
                              input logic [63:0] sp, input logic [2:0] fl);
    vec_t v;
    v.icode = ic; v.ifun = fn; v.ra = ra; v.rb = rb;
    v.valc = vc; v.valp = vp; v.valm = vm;
    v.exp_e = e; v.exp_cnd = c; v.exp_pc = pc;
    v.chk_reg = cr; v.exp_reg = rv; v.exp_rsp = sp; v.exp_flags = fl;
    return v;
  endfunction

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                       input logic [63:0] vm);
    bus.icode = ic; bus.ifun = fn; bus.rA = ra; bus.rB = rb;
    bus.valC = vc; bus.valP = vp; bus.valM = vm;
  endtask

  task automatic read_reg(input logic [3:0] id, input logic [63:0] exp, input string name);
    bus.dbg_id = id;
    #1;
    check(name, bus.dbg_val, exp);
  endtask

  initial begin
    logic [128:0] ec;
    logic [130:0] ep;
    // flags are {ZF,SF,OF}
    vecs[0]  = mk(4'h6,4'h0,4'h1,4'h5, 64'd0,   64'd2,  64'd0,  64'd104, 1'b0, 64'd2,  4'h5, 64'd104, 64'd256, 3'b000);
    vecs[1]  = mk(4'h3,4'h0,4'hF,4'h2, 64'd120, 64'd12, 64'd0,  64'd120, 1'b0, 64'd12, 4'h2, 64'd120, 64'd256, 3'b000);
    vecs[2]  = mk(4'h3,4'h0,4'hF,4'hA, 64'd77,  64'd22, 64'd0,  64'd77,  1'b0, 64'd22, 4'hA, 64'd77,  64'd256, 3'b000);
    vecs[3]  = mk(4'h2,4'h6,4'hA,4'hB, 64'd0,   64'd24, 64'd0,  64'd77,  1'b1, 64'd24, 4'hB, 64'd77,  64'd256, 3'b000);
    vecs[4]  = mk(4'h6,4'h3,4'h2,4'h2, 64'd0,   64'd26, 64'd0,  64'd0,   1'b0, 64'd26, 4'h2, 64'd0,   64'd256, 3'b100);
    vecs[5]  = mk(4'h3,4'h0,4'hF,4'hA, 64'd5,   64'd36, 64'd0,  64'd5,   1'b0, 64'd36, 4'hA, 64'd5,   64'd256, 3'b100);
    vecs[6]  = mk(4'h2,4'h6,4'hA,4'hB, 64'd0,   64'd38, 64'd0,  64'd5,   1'b0, 64'd38, 4'hB, 64'd77,  64'd256, 3'b100);
    vecs[7]  = mk(4'h7,4'h0,4'hF,4'hF, 64'd55,  64'd47, 64'd0,  64'd0,   1'b1, 64'd55, 4'hB, 64'd77,  64'd256, 3'b100);
    vecs[8]  = mk(4'h7,4'h4,4'hF,4'hF, 64'd40,  64'd56, 64'd0,  64'd0,   1'b0, 64'd56, 4'h3, 64'd0,   64'd256, 3'b100);
    vecs[9]  = mk(4'h8,4'h0,4'hF,4'hF, 64'd55,  64'd65, 64'd0,  64'd248, 1'b0, 64'd55, 4'h4, 64'd248, 64'd248, 3'b100);
    vecs[10] = mk(4'hA,4'h0,4'h3,4'hF, 64'd0,   64'd67, 64'd0,  64'd240, 1'b0, 64'd67, 4'h4, 64'd240, 64'd240, 3'b100);
    vecs[11] = mk(4'hB,4'h0,4'h5,4'hF, 64'd0,   64'd69, 64'd7,  64'd248, 1'b0, 64'd69, 4'h5, 64'd7,   64'd248, 3'b100);
    vecs[12] = mk(4'h9,4'h0,4'hF,4'hF, 64'd0,   64'd70, 64'd30, 64'd256, 1'b0, 64'd30, 4'h4, 64'd256, 64'd256, 3'b100);
    vecs[13] = mk(4'h3,4'h0,4'hF,4'h6, 64'h8000_0000_0000_0000, 64'd80, 64'd0, 64'h8000_0000_0000_0000, 1'b0, 64'd80,
                  4'h6, 64'h8000_0000_0000_0000, 64'd256, 3'b100);
    vecs[14] = mk(4'h3,4'h0,4'hF,4'h7, 64'd1,   64'd90, 64'd0,  64'd1,   1'b0, 64'd90, 4'h7, 64'd1,   64'd256, 3'b100);
    vecs[15] = mk(4'h6,4'h1,4'h7,4'h6, 64'd0,   64'd92, 64'd0,  64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 64'd92,
                  4'h6, 64'h7FFF_FFFF_FFFF_FFFF, 64'd256, 3'b001);
    vecs[16] = mk(4'hB,4'h0,4'h4,4'hF, 64'd0,   64'd94, 64'd99, 64'd264, 1'b0, 64'd94, 4'h4, 64'd99,  64'd99,  3'b001);
    vecs[17] = mk(4'h0,4'h0,4'hF,4'hF, 64'd0,   64'd77, 64'd0,  64'd0,   1'b0, 64'd77, 4'h4, 64'd99,  64'd99,  3'b001);
    vecs[18] = mk(4'h7,4'h1,4'hF,4'hF, 64'd5,   64'd100,64'd0,  64'd0,   1'b1, 64'd5,  4'h1, 64'd100, 64'd99,  3'b001);

    // Clock/reset
    reset = 1'b1;
    bus.dbg_id = 4'hF;
    drive(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 64'd0);
    #1;
    check("rst_zf", {63'd0, bus.ZF}, 64'd1);
    check("rst_sf_of", {62'd0, bus.SF, bus.OF}, 64'd0);
    check("rst_rsp_port", bus.rsp, 64'd256);
    check("rst_dbg_none", bus.dbg_val, 64'd0);
    read_reg(4'h1, 64'd100, "rst_rcx");
    read_reg(4'h5, 64'd4, "rst_rbp");
    read_reg(4'h3, 64'd0, "rst_rbx");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].icode, vecs[i].ifun, vecs[i].ra, vecs[i].rb, vecs[i].valc, vecs[i].valp, vecs[i].valm);
      exp_q.push_back({vecs[i].exp_e, vecs[i].exp_cnd, vecs[i].exp_pc});
      post_q.push_back({vecs[i].exp_reg, vecs[i].exp_rsp, vecs[i].exp_flags});
      #1;
      ec = exp_q.pop_front();
      check($sformatf("v%0d_valE", i), bus.valE, ec[128:65]);
      check($sformatf("v%0d_Cnd", i), {63'd0, bus.Cnd}, {63'd0, ec[64]});
      check($sformatf("v%0d_PC_next", i), bus.PC_next, ec[63:0]);
      @(posedge clk);
      #1;
      ep = post_q.pop_front();
      read_reg(vecs[i].chk_reg, ep[130:67], $sformatf("v%0d_reg", i));
      check($sformatf("v%0d_rsp", i), bus.rsp, ep[66:3]);
      check($sformatf("v%0d_flags", i), {61'd0, bus.ZF, bus.SF, bus.OF}, {61'd0, ep[2:0]});
    end

    // Reset mid-instruction: addq rcx,rbp pending, reset before the edge
    @(negedge clk);
    drive(4'h6, 4'h0, 4'h1, 4'h5, 64'd0, 64'd2, 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rsp", bus.rsp, 64'd256);
    check("mid_flags", {61'd0, bus.ZF, bus.SF, bus.OF}, 64'd4);
    read_reg(4'h5, 64'd4, "mid_rbp");
    read_reg(4'h1, 64'd100, "mid_rcx");
    @(posedge clk);
    #1;
    read_reg(4'h5, 64'd4, "mid_rbp_no_wb");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    read_reg(4'h5, 64'd104, "post_rst_addq");

    if (exp_q.size() != 0 || post_q.size() != 0) check("queue_empty", 64'd1, 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
